gray_counter: RTL

GRAY_COUNTER -- requirements
Module: gray_counter

---
 rtl/gray_counter.sv | 69 ++++++
 1 files changed

// File: rtl/gray_counter.sv
// rtl/gray_counter.sv - up/down binary counter with registered Gray-code output and wrap pulse
//
// Purpose: WIDTH-bit unsigned modulo counter with synchronous load. The binary
// count, its Gray encoding and a one-cycle terminal-count pulse are all
// registered on the same rising edge.
//
// Ports:
//   clk       - single clock, all state updates on its rising edge
//   rst       - asynchronous active-high reset, clears all outputs
//   en        - count enable, one step per edge while high
//   dir       - count direction, 1 = up, 0 = down
//   load      - synchronous load strobe, beats en
//   load_val  - binary value taken on load
//   bin_out   - registered binary count
//   gray_out  - registered Gray encoding of bin_out
//   tc        - registered one-cycle pulse after an enabled step that wraps
module gray_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] bin_out,
  output logic [WIDTH-1:0] gray_out,
  output logic             tc
);

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             tc_q, tc_d;

  always_comb begin
    bin_d = bin_q;
    tc_d  = 1'b0;
    if (load) begin
      bin_d = load_val;
    end else if (en) begin
      if (dir) begin
        bin_d = bin_q + 1'b1;
        tc_d  = &bin_q;   // all-ones -> 0
      end else begin
        bin_d = bin_q - 1'b1;
        tc_d  = ~|bin_q;  // 0 -> all-ones
      end
    end
    // Gray is derived from the next binary value so both registers agree every cycle.
    gray_d = bin_d ^ (bin_d >> 1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q  <= '0;
      gray_q <= '0;
      tc_q   <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      tc_q   <= tc_d;
    end
  end

  assign bin_out  = bin_q;
  assign gray_out = gray_q;
  assign tc       = tc_q;

endmodule
